// File: rtl/dac_adc_bus_arbiter_if.sv
// Request/acknowledge and serial-bus bundle shared by the two requesters,
// the DAC/ADC serial pins and dac_adc_bus_arbiter.
interface dac_adc_bus_arbiter_if #(
    parameter int WORD_BITS = 16
) ();
    logic                 iREQ_SEQ;
    logic                 iOP_SEQ;
    logic [WORD_BITS-1:0] iWORD_SEQ;
    logic                 iREQ_HOST;
    logic                 iOP_HOST;
    logic [WORD_BITS-1:0] iWORD_HOST;
    logic                 oACK_SEQ;
    logic                 oACK_HOST;
    logic [WORD_BITS-1:0] oRDATA;
    logic                 oBUSY;
    logic                 DACS;
    logic                 DACLK;
    logic                 DADATA;
    logic                 ADCS;
    logic                 ADCLK;
    logic                 ADDIN;
    logic                 ADDOUT;

    // Requester side plus the ADC data pin.
    modport master (
        output iREQ_SEQ, iOP_SEQ, iWORD_SEQ, iREQ_HOST, iOP_HOST, iWORD_HOST, ADDOUT,
        input  oACK_SEQ, oACK_HOST, oRDATA, oBUSY,
        input  DACS, DACLK, DADATA, ADCS, ADCLK, ADDIN
    );

    // Arbiter side.
    modport slave (
        input  iREQ_SEQ, iOP_SEQ, iWORD_SEQ, iREQ_HOST, iOP_HOST, iWORD_HOST, ADDOUT,
        output oACK_SEQ, oACK_HOST, oRDATA, oBUSY,
        output DACS, DACLK, DADATA, ADCS, ADCLK, ADDIN
    );
endinterface

// File: rtl/dac_adc_bus_arbiter.sv
// Round-robin arbiter between the sequencer (requester 0) and the host
// command path (requester 1) for a shared serial DAC/ADC link. One frame of
// WORD_BITS bits is shifted MSB first per grant; ADC reads capture ADDOUT.
module dac_adc_bus_arbiter #(
    parameter int SCK_HALF  = 4,
    parameter int WORD_BITS = 16
) (
    input logic                  CLK_50,
    input logic                  nRst,
    dac_adc_bus_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] HALF_RELOAD = 8'(SCK_HALF - 1);
    localparam logic [5:0] BIT_RELOAD  = 6'(WORD_BITS - 1);
    localparam logic       SEL_HOST    = 1'b1;

    state_t               state;
    state_t               state_nx;
    logic [7:0]           half_cnt;
    logic [5:0]           bit_cnt;
    logic                 sck_q;
    logic                 op_q;
    logic                 owner_q;
    logic                 last_q;
    logic [WORD_BITS-1:0] tx_q;
    logic [WORD_BITS-1:0] rx_q;
    logic [WORD_BITS-1:0] rdata_q;
    logic                 ack_seq_q;
    logic                 ack_host_q;

    logic                 half_done;
    logic                 any_req;
    logic                 winner;
    logic                 sck_rise;
    logic                 sck_fall;
    logic                 last_fall;
    logic                 cs_active;

    // Shared decode: phase timing, SCK edges and round-robin winner.
    always_comb begin
        half_done = (half_cnt == 8'd0);
        any_req   = bus.iREQ_SEQ | bus.iREQ_HOST;
        // On a tie the requester not served last wins; otherwise the only requester.
        winner    = (bus.iREQ_SEQ & bus.iREQ_HOST) ? ~last_q : bus.iREQ_HOST;
        sck_rise  = (state == SHIFT) & half_done & ~sck_q;
        sck_fall  = (state == SHIFT) & half_done & sck_q;
        last_fall = sck_fall & (bit_cnt == 6'd0);
        cs_active = (state == SETUP) | (state == SHIFT) | (state == HOLD);
    end

    // Next-state logic for the transfer sequence.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req)   state_nx = SETUP;
            SETUP:   if (half_done) state_nx = SHIFT;
            SHIFT:   if (last_fall) state_nx = HOLD;
            HOLD:    if (half_done) state_nx = GAP;
            GAP:     if (half_done) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK_50 or negedge nRst) begin
        if (!nRst) state <= IDLE;
        else       state <= state_nx;
    end

    // Half-period and bit counters, reloaded on every state entry.
    always_ff @(posedge CLK_50 or negedge nRst) begin
        if (!nRst) begin
            half_cnt <= '0;
            bit_cnt  <= '0;
        end else if (state_nx != state) begin
            half_cnt <= HALF_RELOAD;
            bit_cnt  <= BIT_RELOAD;
        end else if (state != IDLE) begin
            if (half_done) half_cnt <= HALF_RELOAD;
            else           half_cnt <= half_cnt - 8'd1;
            if (sck_fall)  bit_cnt  <= bit_cnt - 6'd1;
        end
    end

    // Serial clock: toggles each half period in SHIFT, low everywhere else.
    always_ff @(posedge CLK_50 or negedge nRst) begin
        if (!nRst)                            sck_q <= 1'b0;
        else if ((state == SHIFT) && half_done) sck_q <= ~sck_q;
        else if (state != SHIFT)              sck_q <= 1'b0;
    end

    // Grant capture, transmit shifting on SCK fall, receive sampling on SCK rise.
    always_ff @(posedge CLK_50 or negedge nRst) begin
        if (!nRst) begin
            op_q    <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= SEL_HOST;
            tx_q    <= '0;
            rx_q    <= '0;
        end else begin
            if ((state == IDLE) && any_req) begin
                op_q    <= winner ? bus.iOP_HOST : bus.iOP_SEQ;
                owner_q <= winner;
                last_q  <= winner;
                tx_q    <= winner ? bus.iWORD_HOST : bus.iWORD_SEQ;
            end else if (sck_fall && !last_fall) begin
                tx_q <= {tx_q[WORD_BITS-2:0], 1'b0};
            end
            if (sck_rise && op_q) rx_q <= {rx_q[WORD_BITS-2:0], bus.ADDOUT};
        end
    end

    // Completion: one-cycle ack to the owner, read data published with it.
    always_ff @(posedge CLK_50 or negedge nRst) begin
        if (!nRst) begin
            ack_seq_q  <= 1'b0;
            ack_host_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ack_seq_q  <= 1'b0;
            ack_host_q <= 1'b0;
            if ((state == GAP) && half_done) begin
                ack_seq_q  <= ~owner_q;
                ack_host_q <= owner_q;
                if (op_q) rdata_q <= rx_q;
            end
        end
    end

    // Pin drive: only the device selected by op sees CS, SCK and data.
    always_comb begin
        bus.oACK_SEQ  = ack_seq_q;
        bus.oACK_HOST = ack_host_q;
        bus.oRDATA    = rdata_q;
        bus.oBUSY     = (state != IDLE);
        bus.DACS      = ~(cs_active & ~op_q);
        bus.DACLK     = sck_q & ~op_q;
        bus.DADATA    = cs_active & ~op_q & tx_q[WORD_BITS-1];
        bus.ADCS      = ~(cs_active & op_q);
        bus.ADCLK     = sck_q & op_q;
        bus.ADDIN     = cs_active & op_q & tx_q[WORD_BITS-1];
    end
endmodule

// File: tb/tb_dac_adc_bus_arbiter.sv
// Self-checking bench for dac_adc_bus_arbiter: directed frames, round-robin
// ties, reset abort, request drop, randomized traffic and a small-parameter copy.
module tb_dac_adc_bus_arbiter;
    localparam int W      = 16;
    localparam int H      = 4;
    localparam int LAT    = 1 + (2 * W + 3) * H;
    localparam int CS_LOW = (2 * W + 2) * H;
    localparam int W2     = 8;
    localparam int H2     = 2;
    localparam int LAT2   = 1 + (2 * W2 + 3) * H2;

    logic CLK_50;
    logic nRst;

    dac_adc_bus_arbiter_if #(.WORD_BITS(W))  bus  ();
    dac_adc_bus_arbiter_if #(.WORD_BITS(W2)) sbus ();

    dac_adc_bus_arbiter #(.SCK_HALF(H), .WORD_BITS(W)) dut (
        .CLK_50 (CLK_50),
        .nRst   (nRst),
        .bus    (bus)
    );

    dac_adc_bus_arbiter #(.SCK_HALF(H2), .WORD_BITS(W2)) dut_small (
        .CLK_50 (CLK_50),
        .nRst   (nRst),
        .bus    (sbus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference state: last served requester (0 seq, 1 host) and held read data.
    int           model_last  = 1;
    logic [W-1:0] model_rdata = '0;
    logic [W-1:0] adc_resp    = '0;

    // Monitor results, reset at every grant.
    int   grant_cyc  = 0;
    int   grant_seen = 0;
    int   dacs_low   = 0;
    int   adcs_low   = 0;
    int   stray      = 0;
    logic dac_bits[$];
    logic adc_bits[$];

    initial begin
        CLK_50 = 1'b0;
        forever #10 CLK_50 = ~CLK_50;
    end

    initial begin
        forever begin
            @(posedge CLK_50);
            cyc++;
        end
    end

    // Bus monitor and ADC model: ADC presents its MSB when selected and
    // advances one bit on every ADCLK fall.
    initial begin
        logic busy_d, dacs_d, adcs_d, daclk_d, adclk_d, dadata_d, addin_d;
        int   adc_idx;
        busy_d = 0; dacs_d = 1; adcs_d = 1; daclk_d = 0; adclk_d = 0;
        dadata_d = 0; addin_d = 0; adc_idx = W - 1;
        bus.ADDOUT = 1'b0;
        forever begin
            @(negedge CLK_50);
            if (bus.oBUSY && !busy_d) begin
                grant_cyc = cyc;
                grant_seen++;
                dac_bits.delete();
                adc_bits.delete();
                dacs_low = 0;
                adcs_low = 0;
                stray    = 0;
            end
            if (!bus.DACS) dacs_low++;
            if (!bus.ADCS) adcs_low++;
            if (bus.DACLK && !daclk_d) dac_bits.push_back(bus.DADATA);
            if (bus.ADCLK && !adclk_d) adc_bits.push_back(bus.ADDIN);
            if (bus.DACS && (bus.DACLK || bus.DADATA)) stray++;
            if (bus.ADCS && (bus.ADCLK || bus.ADDIN)) stray++;
            if (!bus.DACS && !dacs_d && (bus.DADATA !== dadata_d) && !(daclk_d && !bus.DACLK)) stray++;
            if (!bus.ADCS && !adcs_d && (bus.ADDIN !== addin_d) && !(adclk_d && !bus.ADCLK)) stray++;
            if (bus.ADCS) adc_idx = W - 1;
            else if (adclk_d && !bus.ADCLK) adc_idx--;
            bus.ADDOUT = (adc_idx >= 0) ? adc_resp[adc_idx] : 1'b0;
            busy_d = bus.oBUSY; dacs_d = bus.DACS; adcs_d = bus.ADCS;
            daclk_d = bus.DACLK; adclk_d = bus.ADCLK;
            dadata_d = bus.DADATA; addin_d = bus.ADDIN;
        end
    end

    task automatic pulse_reset();
        @(negedge CLK_50);
        nRst = 1'b0;
        repeat (2) @(negedge CLK_50);
        nRst = 1'b1;
        model_last  = 1;
        model_rdata = '0;
    endtask

    // Drives n_s / n_h services for each requester, holding each request until
    // its last ack, and scores every ack against the round-robin model.
    task automatic serve_requests(input int n_s, input int n_h, input logic op_s, input logic op_h,
                                  input logic [W-1:0] w_s, input logic [W-1:0] w_h,
                                  input int drop_after);
        int           exp_q[$];
        int           rem_s, rem_h, last, exp_who;
        int           done_s, done_h, acks, total, budget, prev_ack, g_seen;
        logic         op, ack_d;
        logic [W-1:0] word, got;
        rem_s = n_s; rem_h = n_h; last = model_last;
        while (rem_s + rem_h > 0) begin
            if (rem_s > 0 && rem_h > 0) exp_who = (last == 1) ? 0 : 1;
            else                        exp_who = (rem_s > 0) ? 0 : 1;
            exp_q.push_back(exp_who);
            last = exp_who;
            if (exp_who == 0) rem_s--; else rem_h--;
        end
        model_last = last;

        bus.iOP_SEQ = op_s; bus.iWORD_SEQ = w_s;
        bus.iOP_HOST = op_h; bus.iWORD_HOST = w_h;
        bus.iREQ_SEQ = (n_s > 0);
        bus.iREQ_HOST = (n_h > 0);
        done_s = 0; done_h = 0; acks = 0; prev_ack = -1; ack_d = 0;
        total = n_s + n_h;
        budget = total * (LAT + 4) + 10;
        g_seen = grant_seen;
        while (acks < total && budget > 0) begin
            @(negedge CLK_50); #1;
            budget--;
            if (grant_seen != g_seen) begin
                g_seen = grant_seen;
                if (prev_ack >= 0) begin
                    checks++;
                    if (grant_cyc !== prev_ack + 1) begin
                        errors++;
                        $display("FAIL regrant_gap: grant cycle %0d, required %0d", grant_cyc, prev_ack + 1);
                    end
                end
            end
            if (drop_after > 0 && bus.oBUSY && bus.iREQ_SEQ && (cyc - grant_cyc) == drop_after) begin
                bus.iREQ_SEQ  = 1'b0;
                bus.iWORD_SEQ = '1;
            end
            if (bus.oACK_SEQ || bus.oACK_HOST) begin
                checks++;
                if (ack_d) begin
                    errors++;
                    $display("FAIL ack_width: ack high in consecutive cycles, required one-cycle pulse");
                end
                exp_who = exp_q.pop_front();
                checks++;
                if ({bus.oACK_HOST, bus.oACK_SEQ} !== ((exp_who == 1) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL ack_owner: {host,seq}=%b, required owner %0d", {bus.oACK_HOST, bus.oACK_SEQ}, exp_who);
                end
                op   = (exp_who == 1) ? op_h : op_s;
                word = (exp_who == 1) ? w_h : w_s;
                checks++;
                if (cyc + 1 - grant_cyc !== LAT) begin
                    errors++;
                    $display("FAIL latency: %0d cycles, required %0d", cyc + 1 - grant_cyc, LAT);
                end
                if (op) model_rdata = adc_resp;
                checks++;
                if (bus.oRDATA !== model_rdata) begin
                    errors++;
                    $display("FAIL rdata: got %h, required %h", bus.oRDATA, model_rdata);
                end
                got = '0;
                if (op) foreach (adc_bits[i]) got = {got[W-2:0], adc_bits[i]};
                else    foreach (dac_bits[i]) got = {got[W-2:0], dac_bits[i]};
                checks++;
                if ((op ? adc_bits.size() : dac_bits.size()) != W || got !== word) begin
                    errors++;
                    $display("FAIL serial_word: got %h (%0d bits), required %h (%0d bits)", got,
                             op ? adc_bits.size() : dac_bits.size(), word, W);
                end
                checks++;
                if ((op ? adcs_low : dacs_low) != CS_LOW || (op ? dacs_low : adcs_low) != 0 ||
                    (op ? dac_bits.size() : adc_bits.size()) != 0) begin
                    errors++;
                    $display("FAIL chip_select: selected low %0d other low %0d, required %0d and 0",
                             op ? adcs_low : dacs_low, op ? dacs_low : adcs_low, CS_LOW);
                end
                checks++;
                if (stray != 0) begin
                    errors++;
                    $display("FAIL pin_discipline: %0d stray pin events, required 0", stray);
                end
                if (exp_who == 0) begin
                    done_s++;
                    if (done_s == n_s) bus.iREQ_SEQ = 1'b0;
                end else begin
                    done_h++;
                    if (done_h == n_h) bus.iREQ_HOST = 1'b0;
                end
                prev_ack = cyc;
                acks++;
            end
            ack_d = bus.oACK_SEQ || bus.oACK_HOST;
        end
        if (acks < total) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: %0d acks, required %0d", acks, total);
            bus.iREQ_SEQ = 1'b0;
            bus.iREQ_HOST = 1'b0;
        end
        @(negedge CLK_50); #1;
        checks++;
        if ({bus.oACK_SEQ, bus.oACK_HOST, bus.oBUSY} !== 3'b000) begin
            errors++;
            $display("FAIL settle_idle: {ack_seq,ack_host,busy}=%b, required 000",
                     {bus.oACK_SEQ, bus.oACK_HOST, bus.oBUSY});
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge CLK_50);
        #1;
        checks++;
        if ({bus.DACS, bus.ADCS, bus.DACLK, bus.ADCLK, bus.DADATA, bus.ADDIN} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_pins: got %b, required 110000",
                     {bus.DACS, bus.ADCS, bus.DACLK, bus.ADCLK, bus.DADATA, bus.ADDIN});
        end
        checks++;
        if ({bus.oACK_SEQ, bus.oACK_HOST, bus.oBUSY} !== 3'b000 || bus.oRDATA !== '0) begin
            errors++;
            $display("FAIL reset_status: acks/busy %b rdata %h, required 000 and 0",
                     {bus.oACK_SEQ, bus.oACK_HOST, bus.oBUSY}, bus.oRDATA);
        end
        checks++;
        if ({sbus.DACS, sbus.ADCS, sbus.oBUSY} !== 3'b110) begin
            errors++;
            $display("FAIL reset_small: got %b, required 110", {sbus.DACS, sbus.ADCS, sbus.oBUSY});
        end
        @(negedge CLK_50);
        nRst = 1'b1;
        model_last  = 1;
        model_rdata = '0;
    endtask

    task automatic test_dac_write();
        serve_requests(1, 0, 1'b0, 1'b0, 16'hA55A, 16'h0000, 0);
    endtask

    task automatic test_adc_read();
        adc_resp = 16'h0123;
        serve_requests(0, 1, 1'b0, 1'b1, 16'h0000, 16'h0800, 0);
    endtask

    task automatic test_back_to_back();
        pulse_reset();
        serve_requests(2, 2, 1'b0, 1'b0, W'($urandom), W'($urandom), 0);
    endtask

    task automatic test_reset_mid();
        int budget;
        int ack_seen;
        logic [W-1:0] w_h;
        w_h = W'($urandom);
        bus.iOP_HOST = 1'b0; bus.iWORD_HOST = w_h; bus.iREQ_HOST = 1'b1;
        budget = 200;
        while (!(dac_bits.size() >= 7 && !bus.DACS && bus.oBUSY) && budget > 0) begin
            @(negedge CLK_50); #1;
            budget--;
        end
        checks++;
        if (budget == 0) begin
            errors++;
            $display("FAIL reset_mid_reach: bit 7 not reached, dac rises %0d", dac_bits.size());
        end
        bus.iOP_SEQ = 1'b0; bus.iWORD_SEQ = W'($urandom); bus.iREQ_SEQ = 1'b1;
        #2 nRst = 1'b0;
        #1;
        checks++;
        if ({bus.DACS, bus.oBUSY, bus.DACLK, bus.DADATA, bus.oACK_HOST} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_async: {dacs,busy,daclk,dadata,ack_host}=%b, required 10000",
                     {bus.DACS, bus.oBUSY, bus.DACLK, bus.DADATA, bus.oACK_HOST});
        end
        ack_seen = 0;
        repeat (3) begin
            @(negedge CLK_50); #1;
            if (bus.oACK_SEQ || bus.oACK_HOST || bus.oBUSY) ack_seen++;
        end
        checks++;
        if (ack_seen != 0) begin
            errors++;
            $display("FAIL reset_no_ack: %0d cycles with ack/busy in reset, required 0", ack_seen);
        end
        @(negedge CLK_50);
        nRst = 1'b1;
        model_last  = 1;
        model_rdata = '0;
        #1;
        checks++;
        if (bus.oBUSY !== 1'b0) begin
            errors++;
            $display("FAIL release_no_early_grant: busy %b, required 0", bus.oBUSY);
        end
        serve_requests(1, 1, 1'b0, 1'b0, bus.iWORD_SEQ, w_h, 0);
    endtask

    task automatic test_drop_mid();
        serve_requests(1, 0, 1'b0, 1'b0, W'($urandom), W'($urandom), 10);
    endtask

    task automatic test_random();
        int mask;
        for (int n = 0; n < 8; n++) begin
            mask = $urandom_range(1, 3);
            adc_resp = W'($urandom);
            serve_requests(mask & 1, (mask >> 1) & 1, 1'($urandom), 1'($urandom),
                           W'($urandom), W'($urandom), 0);
        end
        serve_requests(2, 1, 1'b1, 1'b0, W'($urandom), W'($urandom), 0);
    endtask

    task automatic test_small_params();
        logic [W2-1:0] word, got;
        int   g, last_rise, budget, nbits;
        logic clk_d, busy_d, done;
        word = W2'($urandom);
        got = '0; g = -1; last_rise = -1; budget = 200; nbits = 0;
        clk_d = 0; busy_d = 0; done = 0;
        sbus.iOP_SEQ = 1'b0; sbus.iWORD_SEQ = word; sbus.iREQ_SEQ = 1'b1;
        while (!done && budget > 0) begin
            @(negedge CLK_50); #1;
            budget--;
            if (sbus.oBUSY && !busy_d) g = cyc;
            if (sbus.DACLK && !clk_d) begin
                got = {got[W2-2:0], sbus.DADATA};
                nbits++;
                if (last_rise >= 0) begin
                    checks++;
                    if (cyc - last_rise != 2 * H2) begin
                        errors++;
                        $display("FAIL small_sck_period: %0d cycles, required %0d", cyc - last_rise, 2 * H2);
                    end
                end
                last_rise = cyc;
            end
            clk_d = sbus.DACLK;
            busy_d = sbus.oBUSY;
            if (sbus.oACK_SEQ) begin
                sbus.iREQ_SEQ = 1'b0;
                done = 1'b1;
                checks++;
                if (cyc + 1 - g != LAT2) begin
                    errors++;
                    $display("FAIL small_latency: %0d cycles, required %0d", cyc + 1 - g, LAT2);
                end
                checks++;
                if (got !== word || nbits != W2) begin
                    errors++;
                    $display("FAIL small_word: got %h (%0d bits), required %h", got, nbits, word);
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL small_timeout: no ack within budget");
            sbus.iREQ_SEQ = 1'b0;
        end
    endtask

    initial begin
        nRst = 1'b0;
        bus.iREQ_SEQ = 0; bus.iOP_SEQ = 0; bus.iWORD_SEQ = '0;
        bus.iREQ_HOST = 0; bus.iOP_HOST = 0; bus.iWORD_HOST = '0;
        sbus.iREQ_SEQ = 0; sbus.iOP_SEQ = 0; sbus.iWORD_SEQ = '0;
        sbus.iREQ_HOST = 0; sbus.iOP_HOST = 0; sbus.iWORD_HOST = '0;
        sbus.ADDOUT = 1'b0;
        test_reset();
        test_dac_write();
        test_adc_read();
        test_back_to_back();
        test_reset_mid();
        test_drop_mid();
        test_random();
        test_small_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dac_adc_bus_arbiter.md
DAC_ADC_BUS_ARBITER -- requirements
Module: dac_adc_bus_arbiter

Interface
REQ-001 Parameter: SCK_HALF, default 4, meaning CLK_50 cycles per serial-clock half period. Legal range is 2..255.
REQ-002 Parameter: WORD_BITS, default 16, meaning serial frame length in bits. Legal range is 8..32.
REQ-003 CLK_50  input  1  system clock, 50 MHz, all logic on its rising edge.
REQ-004 nRst  input  1  reset, asynchronous, active-low.
REQ-005 iREQ_SEQ  input  1  transfer request from the sequencer (requester 0), level, held until ack.
REQ-006 iOP_SEQ  input  1  requester 0 operation: 0 = DAC write, 1 = ADC read.
REQ-007 iWORD_SEQ  input  WORD_BITS  requester 0 transmit word, MSB first.
REQ-008 iREQ_HOST  input  1  transfer request from the host command path (requester 1), level.
REQ-009 iOP_HOST  input  1  requester 1 operation, same encoding as iOP_SEQ.
REQ-010 iWORD_HOST  input  WORD_BITS  requester 1 transmit word (ADC reads carry the channel/config word).
REQ-011 oACK_SEQ / oACK_HOST  output  1 each  one-cycle completion pulse to the served requester.
REQ-012 oRDATA  output  WORD_BITS  word shifted in from ADDOUT; valid in the ack cycle and held until the next ack.
REQ-013 oBUSY  output  1  high in every state except IDLE.
REQ-014 DACS, DACLK, DADATA  output  1 each  DAC chip select (active-low), serial clock, serial data.
REQ-015 ADCS, ADCLK, ADDIN  output  1 each  ADC chip select (active-low), serial clock, serial data.
REQ-016 ADDOUT  input  1  ADC serial data out.

Function
REQ-017 FSM states and order: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE. There are no other states.
REQ-018 IDLE, grant rule: a pending request is granted on the first edge it is sampled high, latching op and word in that edge. FSM moves to SETUP.
REQ-019 Arbitration is round-robin. When both requests are high in IDLE, the requester not served last wins. A single request always wins.
REQ-020 After reset the last-served pointer = host, so requester 0 wins the first tie.
REQ-021 SETUP lasts SCK_HALF cycles. The selected CS is low, SCK is low, and data holds the word MSB.
REQ-022 SHIFT lasts 2*WORD_BITS*SCK_HALF cycles. SCK toggles every SCK_HALF cycles, starting low, giving WORD_BITS rising edges.
REQ-023 During SHIFT, the data output changes only in the cycle SCK falls, advancing to the next bit toward the LSB.
REQ-024 During SHIFT, ADDOUT is sampled in the cycle SCK rises, for ADC reads only, shifted in MSB first.
REQ-025 HOLD lasts SCK_HALF cycles. CS stays low and SCK stays low.
REQ-026 GAP lasts SCK_HALF cycles. Both CS are high and both data outputs are low.
REQ-027 At the end of GAP the FSM returns to IDLE and the served ack is pulsed for exactly one cycle. For ADC reads, oRDATA updates in the same cycle.
REQ-028 Latency: the ack is asserted 1 + (2*WORD_BITS+3)*SCK_HALF cycles after the grant edge. With default parameters this is 141 cycles.
REQ-029 Only the device selected by op is driven: its CS, SCK and data. The other device's CS stays high and its SCK and data stay low.
REQ-030 A DAC write leaves oRDATA unchanged.
REQ-031 If a request drops mid-transfer, the transfer still completes and the ack still pulses.
REQ-032 Request inputs are ignored outside IDLE. Word inputs are ignored after the grant edge.
REQ-033 If a requester holds its request through its ack cycle, it is re-arbitrated in the next IDLE cycle, subject to round-robin.
REQ-034 Counters: the half-period counter is 8 bits and the bit counter is 6 bits. Neither wraps within a state. Each counter reloads on every state entry.

Reset
REQ-035 While nRst is low the block holds these values:
- State IDLE.
- DACS = ADCS = 1.
- DACLK = ADCLK = DADATA = ADDIN = 0.
- oACK_* = 0, oBUSY = 0, oRDATA = 0.
- Pointer = host.
REQ-036 Reset asserted mid-transfer forces the REQ-035 values asynchronously. No ack is issued for the aborted transfer.
REQ-037 After reset release, the first grant occurs no earlier than the first CLK_50 edge with nRst high.

Verification
REQ-038 Seq DAC write of word 0xA55A, default parameters:
- DACS low for 136 cycles.
- 16 DACLK rising edges, with DADATA bits 1,0,1,0,0,1,0,1,0,1,0,1,1,0,1,0 read at the rising edges.
- oACK_SEQ pulses 141 cycles after the grant.
- oRDATA stays 0.
REQ-039 Host ADC read with word 0x0800 and an ADDOUT model returning 0x0123:
- ADCS toggles, DACS stays high.
- ADDIN carries 0x0800.
- oRDATA = 0x0123 in the oACK_HOST cycle.
REQ-040 Both requests rise in the same cycle, both held high:
- Service order is seq, host, seq, host.
- Each grant occurs one cycle after the previous ack.
REQ-041 nRst pulsed low during bit 7 of a host DAC write:
- DACS goes high immediately, oBUSY drops, no ack is issued.
- After release, a pending seq request is granted first.
REQ-042 iREQ_SEQ dropped after 10 cycles of a transfer while iWORD_SEQ changes to 0xFFFF:
- The original word is sent in full.
- oACK_SEQ still pulses.
REQ-043 With SCK_HALF = 2 and WORD_BITS = 8:
- Ack arrives 39 cycles after the grant.
- DACLK period is 4 cycles.
